// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: BCD digit geometry and operand-entry state encoding.
package calc_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ENTRY  = 2'd1,
    FULL   = 2'd2,
    RESULT = 2'd3
  } entry_state_t;

  // Keypad codes above DIGIT_MAX are operators and never enter the operand.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return code <= DIGIT_W'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_sig_digits.sv
// Counts significant BCD digits (index of the most significant non-zero digit plus one).
// Purely combinational, zero latency; no flow control.
module bcd_sig_digits
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  output logic [CNT_W-1:0]              count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (value[DIGIT_W*i +: DIGIT_W] != '0) begin
        count = CNT_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/bcd_entry_register.sv
// Keypad operand-entry register: builds an N-digit BCD operand with backspace, sign toggle and result load.
// Latency 1 Clock_10ms edge, no backpressure; optional memory recall port set under CALC_MEM_RECALL_EN.
module bcd_entry_register
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          Clock_10ms,
  input  logic                          reset,
  input  logic                          entry_en,
  input  logic                          sign_en,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          valid,
  input  logic                          backspace,
  input  logic                          negative,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  input  logic                          load_sign,
`ifdef CALC_MEM_RECALL_EN
  input  logic                          mem_recall,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] mem_value,
  input  logic                          mem_sign,
`endif
  output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_value,
  output logic                          number_sign,
  output logic [CNT_W-1:0]              digit_count,
  output logic                          full,
  output logic                          overflow,
  output logic [1:0]                    state
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  entry_state_t   st;
  logic           do_load;
  logic           do_bs;
  logic           do_digit;
  logic           do_tog;
  logic           clr_sign;
  logic [W-1:0]   ld_value;
  logic           ld_sign;
  logic [CNT_W-1:0] ld_count;
  logic [W-1:0]   shl_value;

  // A recalled memory value is treated as a load of lower priority than the ALU result.
`ifdef CALC_MEM_RECALL_EN
  logic do_result_load;
  logic do_recall;
  assign do_result_load = entry_en & load;
  assign do_recall      = mem_recall & (entry_en | sign_en) & ~do_result_load;
  assign do_load        = do_result_load | do_recall;
  assign ld_value       = do_result_load ? load_value : mem_value;
  assign ld_sign        = do_result_load ? load_sign  : mem_sign;
`else
  assign do_load  = entry_en & load;
  assign ld_value = load_value;
  assign ld_sign  = load_sign;
`endif

  assign do_bs     = entry_en & backspace;
  assign do_digit  = entry_en & valid & is_digit(digit);
  assign do_tog    = sign_en & negative;
  assign clr_sign  = (do_bs | do_digit) & (st == RESULT);
  assign shl_value = W'({bcd_value, digit});

  bcd_sig_digits #(
    .NUM_DIGITS (NUM_DIGITS),
    .CNT_W      (CNT_W)
  ) u_sig_digits (
    .value (ld_value),
    .count (ld_count)
  );

  always_ff @(posedge Clock_10ms) begin
    if (reset) begin
      st          <= EMPTY;
      bcd_value   <= '0;
      number_sign <= 1'b0;
      digit_count <= '0;
      full        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (do_load) begin
        st          <= RESULT;
        bcd_value   <= ld_value;
        number_sign <= ld_sign;
        digit_count <= ld_count;
        full        <= (ld_count == CNT_W'(NUM_DIGITS));
      end else begin
        number_sign <= (number_sign & ~clr_sign) ^ do_tog;
        if (do_bs) begin
          case (st)
            ENTRY, FULL: begin
              bcd_value   <= bcd_value >> DIGIT_W;
              digit_count <= digit_count - CNT_W'(1);
              full        <= 1'b0;
              st          <= (digit_count == CNT_W'(1)) ? EMPTY : ENTRY;
            end
            RESULT: begin
              bcd_value   <= '0;
              digit_count <= '0;
              full        <= 1'b0;
              st          <= EMPTY;
            end
            default: ;
          endcase
        end else if (do_digit) begin
          case (st)
            // RESULT clears first; a zero key then leaves the register EMPTY,
            // which is also the leading-zero suppression case from EMPTY.
            EMPTY, RESULT: begin
              bcd_value   <= W'(digit);
              digit_count <= (digit != '0) ? CNT_W'(1) : '0;
              full        <= (digit != '0) && (NUM_DIGITS == 1);
              if (digit == '0)
                st <= EMPTY;
              else
                st <= (NUM_DIGITS == 1) ? FULL : ENTRY;
            end
            ENTRY: begin
              bcd_value   <= shl_value;
              digit_count <= digit_count + CNT_W'(1);
              full        <= (digit_count == CNT_W'(NUM_DIGITS - 1));
              st          <= (digit_count == CNT_W'(NUM_DIGITS - 1)) ? FULL : ENTRY;
            end
            FULL: begin
              overflow <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign state = st;

endmodule
